// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int ZERO_ADDR  = 0;

  // Low bit of packed port slice idx when each slice is width bits wide.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: issue sets, long-latency writeback clears, set beats clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reg_reset,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic              clr_valid_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [DEPTH-1:0]  busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
    if (ZERO_REG != 0 && gi == ZERO_ADDR) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_live
      logic set_hit;
      logic clr_hit;
      assign set_hit    = iss_valid_i && (iss_addr_i == ADDR_W'(gi));
      assign clr_hit    = clr_valid_i && (clr_addr_i == ADDR_W'(gi));
      // A fresh issue means a new producer is outstanding, so it overrides the clear.
      assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
    end
  end

  always_ff @(posedge clk or negedge reg_reset) begin
    if (!reg_reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational reads, two write ports, optional bypass, busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reg_reset,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     busy_any
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr0_act;
  logic              wr1_act;

  assign wr0_act = we0 && !(ZERO_REG != 0 && wa0 == ADDR_W'(ZERO_ADDR));
  assign wr1_act = we1 && !(ZERO_REG != 0 && wa1 == ADDR_W'(ZERO_ADDR));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (ZERO_REG != 0 && gi == ZERO_ADDR) begin : g_zero
      assign mem_d[gi] = '0;
    end else begin : g_live
      assign mem_d[gi] = (wr1_act && wa1 == ADDR_W'(gi)) ? wd1 :
                         (wr0_act && wa0 == ADDR_W'(gi)) ? wd0 : mem_q[gi];
    end
  end

  always_ff @(posedge clk or negedge reg_reset) begin
    if (!reg_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reg_reset  (reg_reset),
    .iss_valid_i(iss_valid),
    .iss_addr_i (iss_addr),
    .clr_valid_i(we1),
    .clr_addr_i (wa1),
    .busy_o     (busy)
  );

  assign busy_any = |busy;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    localparam int ALO = slice_lo(gi, ADDR_W);
    localparam int DLO = slice_lo(gi, DATA_W);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    assign addr = ra[ALO +: ADDR_W];

    // Port 1 is checked last so it takes priority, matching the storage update.
    always_comb begin
      rdata = mem_q[addr];
      if (BYPASS != 0) begin
        if (wr0_act && wa0 == addr) rdata = wd0;
        if (wr1_act && wa1 == addr) rdata = wd1;
      end
      if (ZERO_REG != 0 && addr == ADDR_W'(ZERO_ADDR)) rdata = '0;
    end

    assign rd[DLO +: DATA_W] = rdata;
    assign rd_busy[gi]       = busy[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a 4-read bypassing instance and a 2-read non-bypassing instance on shared stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reg_reset;
  logic [19:0] ra4;
  logic [9:0]  ra2;
  logic [127:0] rd4;
  logic [63:0]  rd2;
  logic [3:0]  rd_busy4;
  logic [1:0]  rd_busy2;
  logic        busy_any4, busy_any2;
  logic        we0, we1, iss_valid;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  regfile_mp #(.NUM_RD(4), .BYPASS(1)) dut (
    .clk(clk), .reg_reset(reg_reset), .ra(ra4), .rd(rd4), .rd_busy(rd_busy4),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_any(busy_any4)
  );

  regfile_mp #(.NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reg_reset(reg_reset), .ra(ra2), .rd(rd2), .rd_busy(rd_busy2),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_any(busy_any2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_valid = 0;
  endtask

  initial begin
    reg_reset = 0; ra4 = '0; ra2 = '0;
    we0 = 0; we1 = 0; iss_valid = 0;
    wa0 = '0; wa1 = '0; iss_addr = '0; wd0 = '0; wd1 = '0;
    #2;
    check("reset_rd0", rd4[31:0], 32'h0);
    check("reset_busy_any", {31'b0, busy_any4}, 32'h0);
    tick(); tick();
    reg_reset = 1;
    tick();

    // Mid-run reset wipes data and busy state.
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; iss_valid = 1; iss_addr = 4;
    tick(); idle();
    ra4 = {15'b0, 5'd5};
    #1;
    check("pre_reset_r5", rd4[31:0], 32'hDEADBEEF);
    check("pre_reset_busy_any", {31'b0, busy_any4}, 32'h1);
    reg_reset = 0;
    #1;
    check("in_reset_r5", rd4[31:0], 32'h0);
    check("in_reset_busy_any", {31'b0, busy_any4}, 32'h0);
    tick();
    reg_reset = 1;
    tick();
    check("post_reset_r5", rd4[31:0], 32'h0);
    check("post_reset_busy_any", {31'b0, busy_any4}, 32'h0);

    // Same-cycle bypass vs stored value.
    ra4 = {15'b0, 5'd7}; ra2 = {5'b0, 5'd7};
    we0 = 1; wa0 = 7; wd0 = 32'h12345678;
    #1;
    check("bypass_on_r7", rd4[31:0], 32'h12345678);
    check("bypass_off_r7_old", rd2[31:0], 32'h0);
    tick(); idle();
    check("bypass_off_r7_new", rd2[31:0], 32'h12345678);

    // Dual-write collision: port 1 wins for storage and bypass.
    ra4 = {15'b0, 5'd3}; ra2 = {5'b0, 5'd3};
    we0 = 1; wa0 = 3; wd0 = 32'h11; we1 = 1; wa1 = 3; wd1 = 32'h22;
    #1;
    check("collide_bypass", rd4[31:0], 32'h22);
    tick(); idle();
    check("collide_r3_dut", rd4[31:0], 32'h22);
    check("collide_r3_nb", rd2[31:0], 32'h22);

    // Register 0 ignores writes and issues.
    ra4 = '0; ra2 = '0;
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; iss_valid = 1; iss_addr = 0;
    #1;
    check("zero_bypass_rd0", rd4[31:0], 32'h0);
    tick(); idle();
    for (int p = 0; p < 4; p++) check($sformatf("zero_rd%0d", p), rd4[p*32 +: 32], 32'h0);
    check("zero_rd_busy", {28'b0, rd_busy4}, 32'h0);
    check("zero_busy_any", {31'b0, busy_any4}, 32'h0);

    // Scoreboard on r9.
    ra4 = {15'b0, 5'd9};
    iss_valid = 1; iss_addr = 9;
    #1;
    check("sb_issue_same_cycle", {31'b0, rd_busy4[0]}, 32'h0);
    tick(); idle();
    check("sb_issue_busy", {31'b0, rd_busy4[0]}, 32'h1);
    check("sb_issue_busy_any", {31'b0, busy_any4}, 32'h1);
    we0 = 1; wa0 = 9; wd0 = 32'hAA;
    tick(); idle();
    check("sb_we0_still_busy", {31'b0, rd_busy4[0]}, 32'h1);
    check("sb_we0_data", rd4[31:0], 32'hAA);
    we1 = 1; wa1 = 9; wd1 = 32'hBB;
    #1;
    check("sb_we1_same_cycle", {31'b0, rd_busy4[0]}, 32'h1);
    tick(); idle();
    check("sb_we1_cleared", {31'b0, rd_busy4[0]}, 32'h0);
    check("sb_we1_data", rd4[31:0], 32'hBB);
    check("sb_we1_busy_any", {31'b0, busy_any4}, 32'h0);
    iss_valid = 1; iss_addr = 9; we1 = 1; wa1 = 9; wd1 = 32'hCC;
    tick(); idle();
    check("sb_set_wins", {31'b0, rd_busy4[0]}, 32'h1);
    check("sb_set_wins_data", rd4[31:0], 32'hCC);
    iss_valid = 1; iss_addr = 9;
    tick(); idle();
    check("sb_reissue_busy", {31'b0, rd_busy4[0]}, 32'h1);
    we1 = 1; wa1 = 9; wd1 = 32'hDD;
    tick(); idle();
    check("sb_final_clear", {31'b0, busy_any4}, 32'h0);

    // Four read ports on distinct registers.
    we0 = 1; wa0 = 1;  wd0 = 32'h0000_0101; we1 = 1; wa1 = 2;  wd1 = 32'h0000_0202;
    tick();
    we0 = 1; wa0 = 30; wd0 = 32'h0000_3030; we1 = 1; wa1 = 31; wd1 = 32'h0000_3131;
    tick(); idle();
    ra4 = {5'd31, 5'd30, 5'd2, 5'd1};
    ra2 = {5'd31, 5'd2};
    #1;
    check("mp_port0_r1",  rd4[31:0],   32'h0000_0101);
    check("mp_port1_r2",  rd4[63:32],  32'h0000_0202);
    check("mp_port2_r30", rd4[95:64],  32'h0000_3030);
    check("mp_port3_r31", rd4[127:96], 32'h0000_3131);
    check("nb_port0_r2",  rd2[31:0],   32'h0000_0202);
    check("nb_port1_r31", rd2[63:32],  32'h0000_3131);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the MIPS32 CPU datapath.
- Generalises the 2-read/1-write file to:
  - NUM_RD read ports and two write ports (W0 for ALU writeback, W1 for load/long-latency writeback).
  - Optional same-cycle write-to-read bypass.
  - A per-register busy scoreboard, so decode can detect RAW hazards on outstanding long-latency results.
- Sits between decode (read/issue) and writeback.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register address width (derived).
- NUM_RD, 2, number of combinational read ports (1..4).
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the stored value.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- reg_reset  in  1  asynchronous active-low reset.
- ra  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  busy bit of the register addressed by each read port.
- we0  in  1  write enable, port 0 (ALU).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (load/long-latency writeback); also clears busy.
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- iss_valid  in  1  issue of a long-latency op; marks iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issued op.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset: reg_reset low asynchronously clears all registers to 0 and all busy bits to 0.
  - Consequently rd = 0, rd_busy = 0 and busy_any = 0 while reset is asserted and after release.
  - Reset asserted mid-operation discards pending writes and issues in that cycle.
- Storage: flop array updated on the rising edge of clk when reg_reset is high.
- Writes:
  - weN with a valid address writes wdN at the next edge.
  - wa0 == wa1 with both enables: port 1 wins.
  - ZERO_REG=1: writes to address 0 are ignored.
- Reads: combinational, zero latency.
  - BYPASS=1 and ra[i] matches an active write address (wa0/we0 or wa1/we1, address nonzero when ZERO_REG=1): rd[i] returns that write data. Port 1 has priority over port 0.
  - Otherwise rd[i] returns the stored value.
  - ZERO_REG=1 and ra[i] == 0: rd[i] = 0 regardless of bypass.
- Scoreboard: one busy bit per register.
  - iss_valid sets busy[iss_addr] at the next edge.
  - we1 clears busy[wa1] at the next edge.
  - we0 does not touch busy bits.
  - Same-cycle iss_valid and we1 to the same address: set wins, so the bit stays busy (a new producer is outstanding); the data write still happens.
  - ZERO_REG=1: iss_addr == 0 is ignored and busy[0] is constant 0.
  - Issue to an already-busy register: the bit stays set; no counting and no error flag.
- rd_busy[i] = busy[ra[i]], using registered state only (not bypassed by same-cycle issue or clear).
- busy_any is combinational from the registered busy bits.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Decomposition:
- Shared package regfile_pkg:
  - localparam defaults (DATA_W, DEPTH, NUM_RD).
  - ZERO_ADDR.
  - A function for the packed-slice offset.
- One sub-module, regfile_scoreboard: DEPTH busy flops with set/clear priority logic; exports the busy vector. Instanced once in regfile_mp.
- Read muxing and bypass stay in regfile_mp, in a generate loop over NUM_RD.

Test Plan:
- Reset value: assert reg_reset=0 mid-run after writing 0xDEADBEEF to r5, then release -> rd for ra=5 is 0, busy_any=0.
- Bypass: write r7=0x12345678 via port 0 while reading ra0=7 in the same cycle, with BYPASS=1 -> rd0=0x12345678 in that cycle. With BYPASS=0 -> old value in that cycle, new value the next cycle.
- Write collision: we0 and we1 both to r3, wd0=0x11 and wd1=0x22 -> r3 reads 0x22 afterwards; the bypass read in the same cycle also returns 0x22.
- Zero register: we1 to r0 with 0xFFFFFFFF and iss_valid to r0 -> rd=0 on all ports, rd_busy=0, busy_any=0.
- Scoreboard:
  - Issue r9 -> rd_busy=1 on the next cycle.
  - we0 to r9 -> still busy.
  - we1 to r9 -> busy clears the following cycle.
  - Same-cycle issue r9 with we1 r9 -> remains busy and data is written.
- Multi-port: NUM_RD=4, each port reading a different register (1, 2, 30, 31) preloaded with distinct values -> all four values correct in the same cycle.
